// File: rtl/tile_pixel_renderer.sv
// Per-pixel tile renderer: latches tile geometry once per frame, answers inside/edge
// queries through a 2-stage pipeline and publishes the previous frame's tile pixel count.
module tile_pixel_renderer #(
    parameter int          BORDER   = 2,
    parameter logic [23:0] FILL_RGB = 24'h000000,
    parameter logic [23:0] EDGE_RGB = 24'h808080,
    parameter logic [23:0] BG_RGB   = 24'hFFFFFF,
    parameter int          X_MAX    = 639,
    parameter int          Y_MAX    = 479
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [9:0]  BallX,
    input  logic [9:0]  BallY,
    input  logic [9:0]  BallS,
    input  logic        pix_valid,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic [7:0]  Red,
    output logic [7:0]  Green,
    output logic [7:0]  Blue,
    output logic        rgb_valid,
    output logic        in_tile,
    output logic [18:0] tile_pix_cnt,
    output logic        tile_offscreen
);

    localparam logic signed [11:0] BW = 12'(BORDER);

    logic        fc_meta, fc_sync, fc_prev;
    logic        frame_tick;
    logic [9:0]  sh_x, sh_y, sh_s;
    logic signed [11:0] l_e, r_e, t_e, b_e, px, py;
    logic        in_vis, is_inside, on_edge;
    logic        s1_valid, s1_inside, s1_edge;
    logic        counted;
    logic [18:0] run_cnt;

    assign frame_tick = fc_sync & ~fc_prev;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fc_meta <= 1'b0;
            fc_sync <= 1'b0;
            fc_prev <= 1'b0;
        end else begin
            fc_meta <= frame_clk;
            fc_sync <= fc_meta;
            fc_prev <= fc_sync;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sh_x <= '0;
            sh_y <= '0;
            sh_s <= '0;
        end else if (frame_tick) begin
            sh_x <= BallX;
            sh_y <= BallY;
            sh_s <= BallS;
        end
    end

    // 12-bit signed keeps X+S (up to 2046) and X-S (down to -1023) exact
    assign l_e = $signed({2'b00, sh_x}) - $signed({2'b00, sh_s});
    assign r_e = $signed({2'b00, sh_x}) + $signed({2'b00, sh_s});
    assign t_e = $signed({2'b00, sh_y}) - $signed({2'b00, sh_s});
    assign b_e = $signed({2'b00, sh_y}) + $signed({2'b00, sh_s});
    assign px  = $signed({2'b00, DrawX});
    assign py  = $signed({2'b00, DrawY});

    always_comb begin
        in_vis    = (DrawX <= 10'(X_MAX)) && (DrawY <= 10'(Y_MAX));
        is_inside = in_vis && (px >= l_e) && (px <= r_e) && (py >= t_e) && (py <= b_e);
        on_edge   = is_inside && ((px < l_e + BW) || (px > r_e - BW) ||
                                  (py < t_e + BW) || (py > b_e - BW));
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid  <= 1'b0;
            s1_inside <= 1'b0;
            s1_edge   <= 1'b0;
        end else begin
            s1_valid  <= pix_valid;
            s1_inside <= pix_valid & is_inside;
            s1_edge   <= pix_valid & on_edge;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            {Red, Green, Blue} <= '0;
            rgb_valid          <= 1'b0;
            in_tile            <= 1'b0;
        end else begin
            rgb_valid <= s1_valid;
            in_tile   <= s1_inside;
            if (!s1_valid)
                {Red, Green, Blue} <= '0;
            else if (s1_edge)
                {Red, Green, Blue} <= EDGE_RGB;
            else if (s1_inside)
                {Red, Green, Blue} <= FILL_RGB;
            else
                {Red, Green, Blue} <= BG_RGB;
        end
    end

    assign counted = rgb_valid & in_tile;

    // A pixel counted on the tick cycle opens the new frame rather than closing the old one
    always_ff @(posedge Clk) begin
        if (Reset) begin
            run_cnt        <= '0;
            tile_pix_cnt   <= '0;
            tile_offscreen <= 1'b1;
        end else if (frame_tick) begin
            tile_pix_cnt   <= run_cnt;
            tile_offscreen <= (run_cnt == '0);
            run_cnt        <= counted ? 19'd1 : '0;
        end else if (counted && run_cnt != '1) begin
            run_cnt <= run_cnt + 19'd1;
        end
    end

endmodule

// File: tb/tb_tile_pixel_renderer.sv
// Directed + randomized bench for tile_pixel_renderer against a geometric reference model.
module tb_tile_pixel_renderer;

    logic        Clk = 1'b0;
    logic        Reset, frame_clk, pix_valid;
    logic [9:0]  BallX, BallY, BallS, DrawX, DrawY;
    logic [7:0]  Red, Green, Blue;
    logic        rgb_valid, in_tile, tile_offscreen;
    logic [18:0] tile_pix_cnt;

    tile_pixel_renderer dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .BallX(BallX), .BallY(BallY), .BallS(BallS),
        .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
        .Red(Red), .Green(Green), .Blue(Blue),
        .rgb_valid(rgb_valid), .in_tile(in_tile),
        .tile_pix_cnt(tile_pix_cnt), .tile_offscreen(tile_offscreen)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        v;
        logic        t;
        logic [23:0] rgb;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   gx, gy, gs, nx, ny, ns, pend;
    int   model_run, pub_cnt;
    logic pub_off, prev_fc;

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Tile is the square [X-S, X+S] x [Y-S, Y+S] clipped to the visible area;
    // the outline is every tile pixel closer than 2 pixels to a tile side.
    function automatic exp_t model_px(input logic v, input int x, input int y);
        exp_t e;
        int   d;
        e.v = v; e.t = 1'b0; e.rgb = 24'h0;
        if (v) begin
            e.rgb = 24'hFFFFFF;
            if (x >= gx - gs && x <= gx + gs && y >= gy - gs && y <= gy + gs &&
                x <= 639 && y <= 479) begin
                d = min2(min2(x - (gx - gs), (gx + gs) - x), min2(y - (gy - gs), (gy + gs) - y));
                e.t = 1'b1;
                e.rgb = (d < 2) ? 24'h808080 : 24'h000000;
            end
        end
        return e;
    endfunction

    task automatic step(input logic v, input int x, input int y, input logic fc);
        exp_t e, got;
        frame_clk = fc;
        if (fc && !prev_fc) begin
            pub_cnt   = model_run;
            pub_off   = (model_run == 0);
            model_run = 0;
            pend      = 4;
        end
        prev_fc = fc;
        if (pend > 0) begin
            pend--;
            if (pend == 1) begin nx = int'(BallX); ny = int'(BallY); ns = int'(BallS); end
            if (pend == 0) begin gx = nx; gy = ny; gs = ns; end
        end
        e = model_px(v, x, y);
        if (e.t) model_run++;
        exp_q.push_back(e);
        pix_valid = v; DrawX = 10'(x); DrawY = 10'(y);
        @(posedge Clk); #1;
        got = exp_q.pop_front();
        checks++;
        assert ({rgb_valid, in_tile, Red, Green, Blue} === {got.v, got.t, got.rgb})
        else begin
            errors++;
            $error("FAIL pixel: got v=%0b t=%0b rgb=%06h, expected v=%0b t=%0b rgb=%06h",
                   rgb_valid, in_tile, {Red, Green, Blue}, got.v, got.t, got.rgb);
        end
    endtask

    task automatic tick();
        repeat (4) step(1'b0, 0, 0, 1'b1);
        repeat (4) step(1'b0, 0, 0, 1'b0);
    endtask

    task automatic scan(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                step(1'b1, x, y, 1'b0);
    endtask

    task automatic check_cnt(input string tag, input int lit);
        checks++;
        assert (tile_pix_cnt === 19'(pub_cnt) && tile_offscreen === pub_off)
        else begin
            errors++;
            $error("FAIL %s: got cnt=%0d off=%0b, expected cnt=%0d off=%0b",
                   tag, tile_pix_cnt, tile_offscreen, pub_cnt, pub_off);
        end
        if (lit >= 0) begin
            checks++;
            assert ({tile_offscreen, tile_pix_cnt} === {lit == 0, 19'(lit)})
            else begin
                errors++;
                $error("FAIL %s_lit: got cnt=%0d off=%0b, expected cnt=%0d off=%0b",
                       tag, tile_pix_cnt, tile_offscreen, lit, lit == 0);
            end
        end
    endtask

    task automatic probe(input string tag, input int x, input int y, input logic [23:0] rgb);
        step(1'b1, x, y, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        checks++;
        assert ({rgb_valid, Red, Green, Blue} === {1'b1, rgb})
        else begin
            errors++;
            $error("FAIL %s: got v=%0b rgb=%06h, expected v=1 rgb=%06h",
                   tag, rgb_valid, {Red, Green, Blue}, rgb);
        end
    endtask

    task automatic do_reset();
        exp_t idle;
        Reset = 1'b1; pix_valid = 1'b0; frame_clk = 1'b0;
        @(posedge Clk); #1;
        checks++;
        assert ({Red, Green, Blue, rgb_valid, in_tile} === 26'h0 &&
                tile_pix_cnt === 19'd0 && tile_offscreen === 1'b1)
        else begin
            errors++;
            $error("FAIL reset: got rgb=%06h v=%0b t=%0b cnt=%0d off=%0b, expected 0/0/0/0/1",
                   {Red, Green, Blue}, rgb_valid, in_tile, tile_pix_cnt, tile_offscreen);
        end
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        idle.v = 1'b0; idle.t = 1'b0; idle.rgb = 24'h0;
        exp_q.delete();
        exp_q.push_back(idle);
        gx = 0; gy = 0; gs = 0; pend = 0;
        model_run = 0; pub_cnt = 0; pub_off = 1'b1; prev_fc = 1'b0;
    endtask

    initial begin
        int lo_x, hi_x, lo_y, hi_y, x, y;
        logic v;
        BallX = '0; BallY = '0; BallS = '0; DrawX = '0; DrawY = '0;
        pix_valid = 1'b0; frame_clk = 1'b0; Reset = 1'b1;

        // T1 reset
        do_reset();

        // T2 centre tile
        BallX = 10'd240; BallY = 10'd80; BallS = 10'd75;
        tick();
        scan(160, 320, 0, 160);
        tick();
        check_cnt("t2_cnt", 22801);
        probe("t2_fill", 240, 80, 24'h000000);
        probe("t2_edge", 165, 80, 24'h808080);
        probe("t2_bg",   164, 80, 24'hFFFFFF);

        // T3 clipped top-left tile, plus columns beyond the visible area
        BallX = 10'd10; BallY = 10'd5; BallS = 10'd20;
        tick();
        check_cnt("t3_load", -1);
        scan(0, 40, 0, 30);
        for (int xx = 1000; xx <= 1023; xx++) step(1'b1, xx, 5, 1'b0);
        tick();
        check_cnt("t3_cnt", 806);

        // T4 fully off-screen tile
        BallX = 10'd700; BallY = 10'd500; BallS = 10'd10;
        tick();
        scan(620, 639, 460, 479);
        tick();
        check_cnt("t4_cnt", 0);

        // Mid-frame reset: geometry falls back to a 1-pixel tile at (0,0)
        scan(0, 5, 0, 1);
        do_reset();
        scan(0, 3, 0, 2);
        tick();
        check_cnt("rst_shadow", 1);

        // T5 no tearing
        BallX = 10'd240; BallY = 10'd80; BallS = 10'd10;
        tick();
        scan(220, 320, 70, 80);
        BallX = 10'd300;
        scan(220, 320, 81, 90);
        tick();
        check_cnt("t5_frame1", 441);
        scan(220, 320, 70, 90);
        tick();
        check_cnt("t5_frame2", 441);

        // T6 tick on the same cycle a tile pixel is counted
        for (int xx = 295; xx <= 305; xx++) step(1'b1, xx, 80, 1'b0);
        for (int xx = 300; xx <= 303; xx++) step(1'b1, xx, 80, 1'b1);
        repeat (2) step(1'b0, 0, 0, 1'b1);
        repeat (4) step(1'b0, 0, 0, 1'b0);
        check_cnt("t6_pub", 11);
        tick();
        check_cnt("t6_new", 4);

        // Randomized geometry and pixel streams
        for (int r = 0; r < 8; r++) begin
            BallX = 10'($urandom_range(700, 0));
            BallY = 10'($urandom_range(520, 0));
            BallS = (r == 0) ? 10'd0 : 10'($urandom_range(40, 0));
            tick();
            lo_x = int'(BallX) - int'(BallS) - 4; hi_x = int'(BallX) + int'(BallS) + 4;
            lo_y = int'(BallY) - int'(BallS) - 4; hi_y = int'(BallY) + int'(BallS) + 4;
            if (lo_x < 0) lo_x = 0;
            if (hi_x > 639) hi_x = 639;
            if (lo_y < 0) lo_y = 0;
            if (hi_y > 479) hi_y = 479;
            if (lo_x > hi_x) begin lo_x = 0; hi_x = 639; end
            if (lo_y > hi_y) begin lo_y = 0; hi_y = 479; end
            for (int i = 0; i < 800; i++) begin
                v = ($urandom_range(3, 0) != 0);
                x = int'($urandom_range(hi_x, lo_x));
                y = int'($urandom_range(hi_y, lo_y));
                step(v, x, y, 1'b0);
            end
            tick();
            check_cnt("rand_cnt", -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
